// File: rtl/fifo_axis_reader.sv
// Drains a native synchronous FIFO with 1-cycle read latency into an AXI-Stream master via a 2-entry skid buffer.
// Optional packet TLAST generation is enabled by defining FIFO_AXIS_TLAST_EN.
module fifo_axis_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int PKT_LEN    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_empty,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [1:0]            occupancy
);

    logic [1:0]            occ_q, occ_d;
    logic                  inflight_q, inflight_d;
    logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
    logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
    logic                  pop;
    logic                  push;
    logic [2:0]            credit;

    assign m_axis_tvalid = (occ_q != 2'd0);
    assign m_axis_tdata  = buf0_q;
    assign occupancy     = occ_q;
    assign pop           = m_axis_tvalid & m_axis_tready;
    assign push          = inflight_q;

    // Words held or on the wire after this cycle's pop must leave room for one more.
    assign credit     = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign fifo_rd_en = ~rst & ~fifo_empty & ~clr & (credit < 3'd2);

    always_comb begin
        occ_d      = occ_q;
        inflight_d = fifo_rd_en;
        buf0_d     = buf0_q;
        buf1_d     = buf1_q;
        if (clr) begin
            occ_d      = 2'd0;
            inflight_d = 1'b0;
        end else begin
            case ({pop, push})
                2'b10: begin
                    buf0_d = buf1_q;
                    occ_d  = occ_q - 2'd1;
                end
                2'b01: begin
                    if (occ_q == 2'd0) begin
                        buf0_d = fifo_rd_data;
                    end else begin
                        buf1_d = fifo_rd_data;
                    end
                    occ_d = occ_q + 2'd1;
                end
                2'b11: begin
                    if (occ_q == 2'd1) begin
                        buf0_d = fifo_rd_data;
                    end else begin
                        buf0_d = buf1_q;
                        buf1_d = fifo_rd_data;
                    end
                end
                default: begin
                    occ_d = occ_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            buf0_q     <= '0;
            buf1_q     <= '0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
        end
    end

`ifdef FIFO_AXIS_TLAST_EN
    localparam int CNT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(PKT_LEN - 1);

    logic [CNT_W-1:0] count_q, count_d;

    assign m_axis_tlast = m_axis_tvalid & (count_q == LAST_BEAT);

    // Beat counter wraps on the final beat so each packet restarts at zero.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (pop) begin
            count_d = m_axis_tlast ? '0 : count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
`else
    assign m_axis_tlast = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_axis_reader.sv
// Self-checking bench for fifo_axis_reader: a queue-based FIFO model plus a scoreboard of words read but not yet streamed.
// Build with FIFO_AXIS_TLAST_EN defined to exercise packet TLAST (PKT_LEN=4).
module tb_fifo_axis_reader;

    localparam int DW  = 8;
    localparam int PKT = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clr = 1'b0;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rd_data = '0;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b0;
    logic          m_axis_tlast;
    logic [1:0]    occupancy;

    fifo_axis_reader #(.DATA_WIDTH(DW), .PKT_LEN(PKT)) dut (
        .clk          (clk),
        .rst          (rst),
        .clr          (clr),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .fifo_empty   (fifo_empty),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast),
        .occupancy    (occupancy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] pend_q[$];
    logic [DW-1:0] sb[$];
    logic [DW-1:0] out_log[$];
    int            tlast_log[$];
    int            minf = 0;
    int            mbeat = 0;
    int            beat_idx = 0;
    int            n_reads = 0;
    bit            s_pop = 0, s_clr = 0, s_rd = 0, prev_hold = 0;
    logic [31:0]   prev_word = '0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) pend_q.push_back(base + DW'(i));
    endtask

    task automatic waitDrain(input int budget);
        int n;
        n = 0;
        while ((pend_q.size() != 0 || fifo_q.size() != 0 || sb.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain_left", pend_q.size() + fifo_q.size() + sb.size(), 0);
    endtask

    // FIFO environment and scoreboard update; words queued by the stimulus land in the FIFO on the next edge.
    always @(posedge clk) begin
        if (rst) begin
            fifo_rd_data <= '0;
            sb.delete();
            minf  = 0;
            mbeat = 0;
        end else begin
            if (s_pop && sb.size() != 0) void'(sb.pop_front());
            if (s_pop) mbeat++;
            if (s_clr) begin
                sb.delete();
                mbeat = 0;
            end
            if (fifo_rd_en && fifo_q.size() != 0) begin
                logic [DW-1:0] w;
                w = fifo_q.pop_front();
                fifo_rd_data <= w;
                n_reads++;
                if (!s_clr) sb.push_back(w);
            end else begin
                fifo_rd_data <= '0;
            end
            minf = (s_rd && !s_clr) ? 1 : 0;
        end
        while (pend_q.size() != 0) fifo_q.push_back(pend_q.pop_front());
        fifo_empty <= (fifo_q.size() == 0);
    end

    // Compare process: occupancy is words fetched but not streamed, less the one still on the wire.
    always @(negedge clk) begin
        if (rst) begin
            s_pop = 0; s_clr = 0; s_rd = 0; prev_hold = 0; beat_idx = 0;
        end else begin
            bit exp_valid, exp_pop, exp_rd, exp_tlast;
            int mocc;
            mocc      = sb.size() - minf;
            exp_valid = (mocc != 0);
            exp_pop   = exp_valid && m_axis_tready;
            exp_rd    = (fifo_q.size() != 0) && !clr && ((sb.size() - (exp_pop ? 1 : 0)) < 2);
`ifdef FIFO_AXIS_TLAST_EN
            exp_tlast = exp_valid && ((mbeat % PKT) == PKT - 1);
`else
            exp_tlast = 1'b0;
`endif
            checkOutput("tvalid", m_axis_tvalid, exp_valid);
            checkOutput("rd_en", fifo_rd_en, exp_rd);
            checkOutput("occupancy", occupancy, mocc);
            checkOutput("tlast", m_axis_tlast, exp_tlast);
            checkOutput("rd_while_empty", fifo_rd_en & fifo_empty, 0);
            if (exp_valid && sb.size() != 0) checkOutput("tdata", m_axis_tdata, sb[0]);
            if (prev_hold) checkOutput("hold_stable", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, prev_word);
            if (m_axis_tvalid && m_axis_tready) begin
                out_log.push_back(m_axis_tdata);
                beat_idx++;
                if (m_axis_tlast) tlast_log.push_back(beat_idx);
            end
            prev_hold = m_axis_tvalid && !m_axis_tready && !clr;
            prev_word = {22'd0, m_axis_tvalid, m_axis_tlast, m_axis_tdata};
            s_pop = exp_pop;
            s_clr = clr;
            s_rd  = exp_rd;
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int r0, vcnt, first_v, last_v, occ2, mism, sent, cyc;
        logic [DW-1:0] w;
        logic [DW-1:0] exp_in[$];

        // Reset with three words waiting and the consumer ready.
        m_axis_tready = 1'b1;
        pend_q.push_back(8'h11); pend_q.push_back(8'h22); pend_q.push_back(8'h33);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_tvalid", m_axis_tvalid, 0);
        checkOutput("rst_rd_en", fifo_rd_en, 0);
        checkOutput("rst_occ", occupancy, 0);
        checkOutput("rst_tdata", m_axis_tdata, 0);
        checkOutput("rst_tlast", m_axis_tlast, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("t1_rd_en_first", fifo_rd_en, 1);
        checkOutput("t1_tvalid_c0", m_axis_tvalid, 0);
        @(negedge clk);
        checkOutput("t1_tvalid_c1", m_axis_tvalid, 0);
        @(negedge clk);
        checkOutput("t1_tvalid_c2", m_axis_tvalid, 1);
        checkOutput("t1_beat0", m_axis_tdata, 8'h11);
        @(negedge clk);
        checkOutput("t1_beat1", m_axis_tdata, 8'h22);
        @(negedge clk);
        checkOutput("t1_beat2", m_axis_tdata, 8'h33);
        @(negedge clk);
        checkOutput("t1_tvalid_end", m_axis_tvalid, 0);
        checkOutput("t1_rd_en_end", fifo_rd_en, 0);
        checkOutput("t1_beats", out_log.size(), 3);

        // Eight words streamed back to back.
        @(posedge clk); #1;
        out_log.delete();
        r0 = n_reads;
        applyStimulus(8, 8'hA0);
        vcnt = 0; first_v = -1; last_v = -1; occ2 = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (m_axis_tvalid) begin
                vcnt++;
                if (first_v < 0) first_v = i;
                last_v = i;
            end
            if (vcnt > 0 && occupancy == 2'd2) occ2 = 1;
        end
        checkOutput("t2_valid_cycles", vcnt, 8);
        checkOutput("t2_no_gaps", last_v - first_v, 7);
        checkOutput("t2_occ_never_2", occ2, 0);
        checkOutput("t2_reads", n_reads - r0, 8);
        mism = 0;
        for (int i = 0; i < 8; i++) if (i >= out_log.size() || out_log[i] != 8'hA0 + DW'(i)) mism++;
        checkOutput("t2_seq_mismatches", mism, 0);

        // Backpressure: only two words may leave the FIFO.
        @(posedge clk); #1;
        m_axis_tready = 1'b0;
        out_log.delete();
        r0 = n_reads;
        applyStimulus(5, 8'h50);
        repeat (10) @(negedge clk);
        checkOutput("t3_reads", n_reads - r0, 2);
        checkOutput("t3_occ", occupancy, 2);
        checkOutput("t3_tvalid", m_axis_tvalid, 1);
        checkOutput("t3_tdata", m_axis_tdata, 8'h50);
        @(posedge clk); #1 m_axis_tready = 1'b1;
        waitDrain(100);
        checkOutput("t3_beats", out_log.size(), 5);
        mism = 0;
        for (int i = 0; i < 5; i++) if (i >= out_log.size() || out_log[i] != 8'h50 + DW'(i)) mism++;
        checkOutput("t3_seq_mismatches", mism, 0);

        // Random backpressure and random FIFO fill.
        @(posedge clk); #1;
        out_log.delete();
        sent = 0; cyc = 0;
        while (out_log.size() < 256 && cyc < 6000) begin
            @(posedge clk); #1;
            m_axis_tready = 1'($urandom_range(0, 1));
            if (sent < 256 && $urandom_range(0, 3) != 0) begin
                w = DW'($urandom);
                pend_q.push_back(w);
                exp_in.push_back(w);
                sent++;
            end
            cyc++;
        end
        m_axis_tready = 1'b1;
        waitDrain(100);
        checkOutput("t4_beats", out_log.size(), 256);
        mism = 0;
        for (int i = 0; i < 256; i++) if (i >= out_log.size() || i >= exp_in.size() || out_log[i] != exp_in[i]) mism++;
        checkOutput("t4_seq_mismatches", mism, 0);

        // Flush with one word buffered and one in flight.
        @(posedge clk); #1;
        m_axis_tready = 1'b0;
        out_log.delete();
        r0 = n_reads;
        pend_q.push_back(8'hC1); pend_q.push_back(8'hC2); pend_q.push_back(8'hC3); pend_q.push_back(8'hC4);
        repeat (3) @(posedge clk);
        #1 clr = 1'b1;
        @(negedge clk);
        checkOutput("t5_occ_before", occupancy, 1);
        checkOutput("t5_rd_en_clr", fifo_rd_en, 0);
        checkOutput("t5_reads_before", n_reads - r0, 2);
        @(posedge clk); #1;
        clr = 1'b0;
        m_axis_tready = 1'b1;
        @(negedge clk);
        checkOutput("t5_tvalid_after", m_axis_tvalid, 0);
        checkOutput("t5_occ_after", occupancy, 0);
        waitDrain(100);
        checkOutput("t5_beats", out_log.size(), 2);
        if (out_log.size() == 2) begin
            checkOutput("t5_resume0", out_log[0], 8'hC3);
            checkOutput("t5_resume1", out_log[1], 8'hC4);
        end

        // Reset in the middle of a stream, then packet framing from a clean start.
        @(posedge clk); #1;
        applyStimulus(6, 8'h60);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_tvalid", m_axis_tvalid, 0);
        checkOutput("midrst_rd_en", fifo_rd_en, 0);
        checkOutput("midrst_occ", occupancy, 0);
        checkOutput("midrst_tdata", m_axis_tdata, 0);
        checkOutput("midrst_tlast", m_axis_tlast, 0);
        @(posedge clk); #1 rst = 1'b0;
        waitDrain(100);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        out_log.delete();
        tlast_log.delete();
        applyStimulus(10, 8'h70);
        waitDrain(200);
        checkOutput("t6_beats", out_log.size(), 10);
`ifdef FIFO_AXIS_TLAST_EN
        checkOutput("t6_tlast_count", tlast_log.size(), 2);
        if (tlast_log.size() == 2) begin
            checkOutput("t6_tlast_first", tlast_log[0], 4);
            checkOutput("t6_tlast_second", tlast_log[1], 8);
        end
`else
        checkOutput("t6_tlast_count", tlast_log.size(), 0);
`endif

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
